// File: rtl/alu_sequencer_if.sv
// Control bundle between the instruction source and the datapath sequencer.
// Signals:
//   Exec/INSTR             start request and 10-bit instruction word (to sequencer)
//   ExtLoad/Gout/Rout      bus-driver enables (at most one active per cycle)
//   Rin/Ain/Gin/FN         register-file and ALU load strobes, ALU function
//   Busy/Done/Step         status: not idle, final-step pulse, current time step
interface alu_sequencer_if;
    localparam int unsigned INSTR_W = 10;
    localparam int unsigned NREG    = 4;
    localparam int unsigned FN_W    = 4;
    localparam int unsigned STEP_W  = 2;

    logic                  Exec;
    logic [INSTR_W-1:0]    INSTR;
    logic                  ExtLoad;
    logic [NREG-1:0]       Rin;
    logic [NREG-1:0]       Rout;
    logic                  Ain;
    logic                  Gin;
    logic                  Gout;
    logic [FN_W-1:0]       FN;
    logic                  Busy;
    logic                  Done;
    logic [STEP_W-1:0]     Step;

    modport master (
        output Exec, INSTR,
        input  ExtLoad, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done, Step
    );

    modport slave (
        input  Exec, INSTR,
        output ExtLoad, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done, Step
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer for the 10-bit bus datapath.
// Captures one instruction per Exec in IDLE and walks T1..T3, issuing the
// register-file / ALU / bus-driver strobes for that instruction class.
// Ports:
//   CLKb   clock, all state changes on the falling edge
//   Clear  synchronous active-high reset (falling edge), overrides Exec
//   seq    control bundle (slave side), see alu_sequencer_if
module alu_sequencer (
    input  logic           CLKb,
    input  logic           Clear,
    alu_sequencer_if.slave seq
);
    localparam int unsigned IR_W = 8;   // INSTR[9:2]; INSTR[1:0] is reserved
    localparam int unsigned NREG = 4;
    localparam int unsigned FN_W = 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_T1 = 2'd1, S_T2 = 2'd2, S_T3 = 2'd3} state_t;
    typedef enum logic [2:0] {C_LOAD, C_MOV, C_BIN, C_UNA, C_SHF, C_ILL} cls_t;

    // Opcode to instruction class; anything unlisted is illegal.
    function automatic cls_t classify(input logic [FN_W-1:0] op);
        cls_t c;
        case (op)
            4'b0000:                                  c = C_LOAD;
            4'b0001:                                  c = C_MOV;
            4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: c = C_BIN;
            4'b0100, 4'b0101:                         c = C_UNA;
            4'b1001, 4'b1010, 4'b1011:                c = C_SHF;
            default:                                  c = C_ILL;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    cls_t               cls_cur, cls_nxt;
    logic [NREG-1:0]    rx_oh, ry_oh;

    logic               ext_q, ext_d;
    logic [NREG-1:0]    rin_q, rin_d;
    logic [NREG-1:0]    rout_q, rout_d;
    logic               ain_q, ain_d;
    logic               gin_q, gin_d;
    logic               gout_q, gout_d;
    logic [FN_W-1:0]    fn_q, fn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Reserved instruction bits are deliberately dropped.
    logic unused_instr;
    assign unused_instr = &{1'b0, seq.INSTR[1:0]};

    // Next state, then strobes decoded from the state being entered so the
    // registered outputs line up with the Moore decode of that state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ext_d   = 1'b0;
        rin_d   = '0;
        rout_d  = '0;
        ain_d   = 1'b0;
        gin_d   = 1'b0;
        gout_d  = 1'b0;
        fn_d    = '0;
        done_d  = 1'b0;

        cls_cur = classify(ir_q[7:4]);
        case (state_q)
            S_IDLE: begin
                if (seq.Exec) begin
                    state_d = S_T1;
                    ir_d    = seq.INSTR[9:2];
                end
            end
            S_T1: begin
                case (cls_cur)
                    C_BIN, C_UNA, C_SHF: state_d = S_T2;
                    default:             state_d = S_IDLE;
                endcase
            end
            S_T2:    state_d = (cls_cur == C_SHF) ? S_IDLE : S_T3;
            default: state_d = S_IDLE;
        endcase

        cls_nxt = classify(ir_d[7:4]);
        rx_oh   = NREG'(4'b0001 << ir_d[3:2]);
        ry_oh   = NREG'(4'b0001 << ir_d[1:0]);
        case (state_d)
            S_T1: begin
                case (cls_nxt)
                    C_LOAD: begin ext_d = 1'b1; rin_d = rx_oh; done_d = 1'b1; end
                    C_MOV:  begin rout_d = ry_oh; rin_d = rx_oh; done_d = 1'b1; end
                    C_BIN, C_UNA: begin rout_d = ry_oh; ain_d = 1'b1; end
                    C_SHF:  begin rout_d = rx_oh; fn_d = ir_d[7:4]; gin_d = 1'b1; end
                    default: done_d = 1'b1;
                endcase
            end
            S_T2: begin
                case (cls_nxt)
                    C_BIN: begin rout_d = rx_oh; fn_d = ir_d[7:4]; gin_d = 1'b1; end
                    C_UNA: begin fn_d = ir_d[7:4]; gin_d = 1'b1; end
                    C_SHF: begin gout_d = 1'b1; rin_d = rx_oh; done_d = 1'b1; end
                    default: ;
                endcase
            end
            S_T3: begin gout_d = 1'b1; rin_d = rx_oh; done_d = 1'b1; end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, IR and strobe registers; Clear drops everything to IDLE at once.
    always_ff @(negedge CLKb) begin
        if (Clear) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            ext_q   <= 1'b0;
            rin_q   <= '0;
            rout_q  <= '0;
            ain_q   <= 1'b0;
            gin_q   <= 1'b0;
            gout_q  <= 1'b0;
            fn_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ext_q   <= ext_d;
            rin_q   <= rin_d;
            rout_q  <= rout_d;
            ain_q   <= ain_d;
            gin_q   <= gin_d;
            gout_q  <= gout_d;
            fn_q    <= fn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seq.ExtLoad = ext_q;
    assign seq.Rin     = rin_q;
    assign seq.Rout    = rout_q;
    assign seq.Ain     = ain_q;
    assign seq.Gin     = gin_q;
    assign seq.Gout    = gout_q;
    assign seq.FN      = fn_q;
    assign seq.Busy    = busy_q;
    assign seq.Done    = done_q;
    assign seq.Step    = state_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small register-file/ALU model
// driven by the sequencer strobes.
module tb_alu_sequencer;
    logic CLKb;
    logic Clear;
    alu_sequencer_if sif ();

    alu_sequencer dut (.CLKb(CLKb), .Clear(Clear), .seq(sif));

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    int n_cmp = 0;
    int n_bad = 0;
    logic armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Datapath model: four registers, Temp (A), G, shared bus.
    logic [9:0] regs [4];
    logic [9:0] a_r, g_r, ext_data, bus_val;
    initial begin
        for (int i = 0; i < 4; i++) regs[i] = 10'h000;
        a_r = 10'h000;
        g_r = 10'h000;
        ext_data = 10'h000;
    end

    function automatic logic [9:0] alu(input logic [3:0] fn, input logic [9:0] a, input logic [9:0] b);
        case (fn)
            4'b0010: return 10'(a + b);
            4'b0011: return 10'(b - a);
            4'b0100: return 10'(-a);
            4'b0101: return ~a;
            4'b0110: return a & b;
            4'b0111: return a | b;
            4'b1000: return a ^ b;
            4'b1001: return {b[8:0], 1'b0};
            4'b1010: return {1'b0, b[9:1]};
            4'b1011: return {b[9], b[9:1]};
            default: return 10'h000;
        endcase
    endfunction

    always_comb begin
        bus_val = 10'h000;
        if (sif.ExtLoad) bus_val = ext_data;
        else if (sif.Gout) bus_val = g_r;
        else begin
            for (int i = 0; i < 4; i++) if (sif.Rout[i]) bus_val = regs[i];
        end
    end

    always @(negedge CLKb) begin
        for (int i = 0; i < 4; i++) if (sif.Rin[i] === 1'b1) regs[i] <= bus_val;
        if (sif.Ain === 1'b1) a_r <= bus_val;
        if (sif.Gin === 1'b1) g_r <= alu(sif.FN, a_r, bus_val);
    end

    // Bus invariant, checked every cycle once out of reset.
    always @(posedge CLKb) begin
        if (armed) begin
            int drv;
            logic ok;
            drv = int'(sif.ExtLoad) + int'(sif.Gout) + $countones(sif.Rout);
            ok = (drv <= 1) && $onehot0(sif.Rin) && $onehot0(sif.Rout);
            chk("bus_inv", 32'(ok), 32'd1);
        end
    end

    logic [19:0] out_vec;
    assign out_vec = {sif.ExtLoad, sif.Rin, sif.Rout, sif.Ain, sif.Gin, sif.Gout,
                      sif.FN, sif.Busy, sif.Done, sif.Step};

    function automatic logic [19:0] mk(input logic ext, input logic [3:0] rin, input logic [3:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic [3:0] fn, input logic done, input logic [1:0] step);
        return {ext, rin, rout, ain, gin, gout, fn, (step != 2'd0), done, step};
    endfunction

    localparam logic [19:0] IDLE_V = 20'h00000;

    // Wait for mid-cycle and compare the full strobe vector.
    task automatic expect_step(input string tag, input logic [19:0] e);
        @(posedge CLKb);
        chk(tag, 32'(out_vec), 32'(e));
    endtask

    task automatic issue(input logic [9:0] instr);
        sif.INSTR = instr;
        sif.Exec  = 1'b1;
    endtask

    task automatic do_load(input logic [1:0] r, input logic [9:0] d);
        ext_data = d;
        issue({4'b0000, r, 4'b0000});
        expect_step("ld_t1", mk(1'b1, 4'(4'b0001 << r), 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1));
        sif.Exec = 1'b0;
        expect_step("ld_idle", IDLE_V);
    endtask

    initial begin
        Clear = 1'b1;
        sif.Exec = 1'b1;
        sif.INSTR = 10'b0000_10_00_00;
        repeat (2) @(posedge CLKb);
        chk("reset_over_exec", 32'(out_vec), 32'(IDLE_V));
        sif.Exec = 1'b0;
        Clear = 1'b0;
        armed = 1'b1;
        expect_step("reset_idle", IDLE_V);

        // LOAD R2 <- 0x155
        ext_data = 10'h155;
        issue(10'b0000_10_00_00);
        expect_step("load_t1", mk(1'b1, 4'b0100, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1));
        sif.Exec = 1'b0;
        expect_step("load_idle", IDLE_V);
        chk("load_r2", 32'(regs[2]), 32'h155);

        // ADD R1,R2 with wrap
        do_load(2'd1, 10'h003);
        do_load(2'd2, 10'h3FF);
        issue(10'b0010_01_10_00);
        expect_step("add_t1", mk(1'b0, 4'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("add_t2", mk(1'b0, 4'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd2));
        expect_step("add_t3", mk(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd3));
        expect_step("add_idle", IDLE_V);
        chk("add_r1", 32'(regs[1]), 32'h002);

        // ASR R3, then LSR R3
        do_load(2'd3, 10'h201);
        issue(10'b1011_11_00_00);
        expect_step("asr_t1", mk(1'b0, 4'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("asr_t2", mk(1'b0, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd2));
        expect_step("asr_idle", IDLE_V);
        chk("asr_r3", 32'(regs[3]), 32'h300);
        do_load(2'd3, 10'h201);
        issue(10'b1010_11_00_00);
        expect_step("lsr_t1", mk(1'b0, 4'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("lsr_t2", mk(1'b0, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd2));
        expect_step("lsr_idle", IDLE_V);
        chk("lsr_r3", 32'(regs[3]), 32'h100);

        // Illegal opcode: Done only
        issue(10'b1110_01_10_00);
        expect_step("ill_t1", mk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1));
        sif.Exec = 1'b0;
        expect_step("ill_idle", IDLE_V);
        chk("ill_r1", 32'(regs[1]), 32'h002);
        chk("ill_r2", 32'(regs[2]), 32'h3FF);

        // MOV R0,R2
        issue(10'b0001_00_10_00);
        expect_step("mov_t1", mk(1'b0, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1));
        sif.Exec = 1'b0;
        expect_step("mov_idle", IDLE_V);
        chk("mov_r0", 32'(regs[0]), 32'h3FF);

        // SUB R1,R0 aborted by Clear in T2
        issue(10'b0011_01_00_00);
        expect_step("suba_t1", mk(1'b0, 4'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("suba_t2", mk(1'b0, 4'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd2));
        Clear = 1'b1;
        expect_step("suba_clr", IDLE_V);
        Clear = 1'b0;
        expect_step("suba_idle", IDLE_V);
        chk("suba_r1", 32'(regs[1]), 32'h002);

        // SUB R1,R0 complete: 0x002 - 0x3FF
        issue(10'b0011_01_00_00);
        expect_step("sub_t1", mk(1'b0, 4'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("sub_t2", mk(1'b0, 4'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd2));
        expect_step("sub_t3", mk(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd3));
        expect_step("sub_idle", IDLE_V);
        chk("sub_r1", 32'(regs[1]), 32'h003);

        // NEG R3 <- -R1
        issue(10'b0100_11_01_00);
        expect_step("neg_t1", mk(1'b0, 4'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd1));
        sif.Exec = 1'b0;
        expect_step("neg_t2", mk(1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd2));
        expect_step("neg_t3", mk(1'b0, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd3));
        expect_step("neg_idle", IDLE_V);
        chk("neg_r3", 32'(regs[3]), 32'h3FD);

        // Exec held through ADD R1,R1; INSTR change while busy must be ignored,
        // and the held Exec recaptures only after one IDLE cycle.
        issue(10'b0010_01_01_00);
        expect_step("hold_t1", mk(1'b0, 4'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd1));
        sif.INSTR = 10'b1111_00_00_00;
        expect_step("hold_t2", mk(1'b0, 4'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd2));
        expect_step("hold_t3", mk(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 2'd3));
        expect_step("hold_idle", IDLE_V);
        expect_step("hold_recap", mk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1));
        sif.Exec = 1'b0;
        expect_step("hold_end", IDLE_V);
        chk("hold_r1", 32'(regs[1]), 32'h006);

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
